// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared types and sizing helper for the memory arbiter
// Revision    : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int ctr_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_wait_ctr.sv
`default_nettype none
// ============================================================================
// arb_wait_ctr : loadable down-counter with zero flag for memory wait cycles
// Revision     : 1.0
// ============================================================================
module arb_wait_ctr #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count;

    // Parks at zero; the FSM leaves ACC on the zero cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one memory port between the CPU and a debug loader,
//               with programmable wait cycles and a one-cycle ack per access
// Revision    : 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int WAIT    = 2,
    parameter int DBG_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int            CW         = ctr_width(WAIT);
    localparam int            SW         = ctr_width(DBG_MAX);
    localparam logic [CW-1:0] WAIT_LD    = CW'(WAIT);
    localparam logic [SW-1:0] STREAK_MAX = SW'(DBG_MAX);

    state_t        state;
    state_t        state_next;
    req_id_t       owner;
    req_id_t       grant_id;
    logic          grant;
    logic          ctr_load;
    logic          ctr_dec;
    logic          ctr_zero;
    logic          capture;
    logic          acc_we;
    logic [SW-1:0] streak;

    arb_wait_ctr #(
        .CW (CW)
    ) u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (WAIT_LD),
        .dec      (ctr_dec),
        .zero     (ctr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_id   = REQ_CPU;
        ctr_load   = 1'b0;
        ctr_dec    = 1'b0;
        capture    = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                // Debug normally wins; a pending CPU is forced through once
                // debug has taken DBG_MAX grants in a row.
                if (dbg_req && !(cpu_req && (streak == STREAK_MAX))) begin
                    grant    = 1'b1;
                    grant_id = REQ_DBG;
                end else if (cpu_req) begin
                    grant    = 1'b1;
                    grant_id = REQ_CPU;
                end
                if (grant) begin
                    ctr_load   = 1'b1;
                    state_next = ACC;
                end
            end
            ACC: begin
                ctr_dec = 1'b1;
                if (ctr_zero) begin
                    mem_we     = acc_we;
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= REQ_CPU;
            acc_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant) begin
            owner     <= grant_id;
            acc_we    <= (grant_id == REQ_DBG) ? dbg_we    : cpu_we;
            mem_addr  <= (grant_id == REQ_DBG) ? dbg_addr  : cpu_addr;
            mem_wdata <= (grant_id == REQ_DBG) ? dbg_wdata : cpu_wdata;
        end
    end

    // Read data is kept per requester so a write never disturbs it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else if (capture && !acc_we) begin
            if (owner == REQ_DBG) begin
                dbg_rdata <= mem_rdata;
            end else begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= '0;
        end else if (grant) begin
            if ((grant_id == REQ_DBG) && cpu_req) begin
                if (streak != STREAK_MAX) begin
                    streak <= streak + SW'(1);
                end
            end else begin
                streak <= '0;
            end
        end
    end

    assign cpu_ack = (state == DONE) && (owner == REQ_CPU);
    assign dbg_ack = (state == DONE) && (owner == REQ_DBG);
    assign busy    = (state != IDLE);

endmodule
`default_nettype wire
